hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; drives the stall, flush and forwarding inputs of the ID/EX stage register and the surrounding stage registers.
- Keeps a 3-entry sequential scoreboard of in-flight destination registers (EX, MEM, WB) mirroring what the stage registers carry.
- Produces:
  - load-use stalls;
  - branch-taken flushes;
  - EX-stage forwarding selects.

---
 rtl/hazard_if.sv | 31 +++
 rtl/hazard_unit.sv | 81 ++++++++
 tb/tb_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: ID-stage operands, branch kill and the stall/flush/forward controls exchanged with hazard_unit.
interface hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_ADDR_W-1:0] id_Rs;
  logic [REG_ADDR_W-1:0] id_Rt;
  logic                  id_UseRs;
  logic                  id_UseRt;
  logic [REG_ADDR_W-1:0] id_Dst;
  logic                  id_RegWrite;
  logic                  id_MemtoReg;
  logic                  BranchTakenM;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushM;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [CNT_W-1:0]      StallCnt;
  logic [CNT_W-1:0]      FlushCnt;
  modport master (
    output id_Rs, id_Rt, id_UseRs, id_UseRt, id_Dst, id_RegWrite, id_MemtoReg, BranchTakenM,
    input  StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, StallCnt, FlushCnt
  );
  modport slave (
    input  id_Rs, id_Rt, id_UseRs, id_UseRt, id_Dst, id_RegWrite, id_MemtoReg, BranchTakenM,
    output StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush and EX forwarding for the 5-stage MIPS pipe.
// Defining HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic     CLK,
  input logic     RST_N,
  hazard_if.slave hz
);
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [REG_ADDR_W-1:0] dst;
  } stage_t;
  stage_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic e_load_q, e_load_d;
  logic [REG_ADDR_W-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
  logic stall, kill, flush_e;
  function automatic logic hit(input stage_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.wr & (s.dst != '0) & (s.dst == r);
  endfunction
  // The load flag only matters while the load sits in EX, so M and W drop it.
  always_comb begin
    stall = e_q.valid & e_load_q & (e_q.dst != '0) &
            ((hz.id_UseRs & (hz.id_Rs == e_q.dst)) | (hz.id_UseRt & (hz.id_Rt == e_q.dst)));
    kill = hz.BranchTakenM & RST_N;
    flush_e = kill | stall;
    hz.StallF = stall & ~kill;
    hz.StallD = stall & ~kill;
    hz.FlushD = kill;
    hz.FlushE = flush_e;
    hz.FlushM = kill;
    hz.ForwardAE = !e_q.valid ? 2'b00 : hit(m_q, e_rs_q) ? 2'b10 : hit(w_q, e_rs_q) ? 2'b01 : 2'b00;
    hz.ForwardBE = !e_q.valid ? 2'b00 : hit(m_q, e_rt_q) ? 2'b10 : hit(w_q, e_rt_q) ? 2'b01 : 2'b00;
    w_d = m_q;
    m_d = kill ? '0 : e_q;
    e_d = flush_e ? '0 : '{valid: 1'b1, wr: hz.id_RegWrite, dst: hz.id_Dst};
    e_load_d = ~flush_e & hz.id_MemtoReg;
    e_rs_d = flush_e ? '0 : hz.id_Rs;
    e_rt_d = flush_e ? '0 : hz.id_Rt;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
      e_load_q <= 1'b0;
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
      e_load_q <= e_load_d;
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (stall & ~kill & ~(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (kill & ~(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = CNT_W'(0);
  assign hz.FlushCnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against an in-flight instruction queue model.
module tb_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 16;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  hazard_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();
  hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.CLK(CLK), .RST_N(RST_N), .hz(hz));
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    bit [4:0] dst;
    bit [4:0] rs;
    bit [4:0] rt;
  } ins_t;
  ins_t q[$];
  int total = 0;
  int bad = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] dst, input bit rw, input bit ld, input bit br);
    hz.id_Rs = rs;
    hz.id_Rt = rt;
    hz.id_UseRs = urs;
    hz.id_UseRt = urt;
    hz.id_Dst = dst;
    hz.id_RegWrite = rw;
    hz.id_MemtoReg = ld;
    hz.BranchTakenM = br;
    #2;
  endtask
  task automatic nop(input bit br = 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, br);
  endtask
  task automatic model_reset();
    ins_t z;
    z = '{default: 0};
    q = {};
    repeat (3) q.push_back(z);
    exp_sc = 0;
    exp_fc = 0;
  endtask
  // q[0] is the instruction in EX, q[1] in MEM, q[2] in WB
  function automatic bit m_stall();
    return q[0].v && q[0].ld && q[0].dst != 0 &&
           ((hz.id_UseRs && hz.id_Rs == q[0].dst) || (hz.id_UseRt && hz.id_Rt == q[0].dst));
  endfunction
  function automatic bit m_kill();
    return RST_N && hz.BranchTakenM;
  endfunction
  function automatic bit [1:0] m_fwd(input bit [4:0] src);
    if (!q[0].v) return 2'b00;
    for (int i = 1; i < 3; i++)
      if (q[i].v && q[i].wr && q[i].dst != 0 && q[i].dst == src) return (i == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  function automatic bit [8:0] m_outs();
    bit s, k;
    s = m_stall();
    k = m_kill();
    return {s && !k, s && !k, k, k || s, k, m_fwd(q[0].rs), m_fwd(q[0].rt)};
  endfunction
  task automatic tick();
    bit s, k;
    ins_t n;
    s = m_stall();
    k = m_kill();
    if (k) q[0].v = 0;
    n.v = !(s || k);
    n.wr = n.v && hz.id_RegWrite;
    n.ld = n.v && hz.id_MemtoReg;
    n.dst = n.v ? hz.id_Dst : 5'd0;
    n.rs = n.v ? hz.id_Rs : 5'd0;
    n.rt = n.v ? hz.id_Rt : 5'd0;
    q.push_front(n);
    void'(q.pop_back());
    if (s && !k && exp_sc < 65535) exp_sc++;
    if (k && exp_fc < 65535) exp_fc++;
    @(posedge CLK);
    #1;
  endtask
  function automatic bit [8:0] outs();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.FlushM, hz.ForwardAE, hz.ForwardBE};
  endfunction
  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (outs() !== 9'd0) begin bad++; $display("FAIL reset_outs: got %b want %b", outs(), 9'd0); end
      total++;
      if ({hz.StallCnt, hz.FlushCnt} !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {hz.StallCnt, hz.FlushCnt}); end
      @(posedge CLK);
      #1;
    end
    RST_N = 1'b1;
    model_reset();
    nop();
    total++;
    if ({hz.ForwardAE, hz.ForwardBE, hz.FlushE} !== 5'd0) begin
      bad++; $display("FAIL reset_release: got %b want %b", {hz.ForwardAE, hz.ForwardBE, hz.FlushE}, 5'd0);
    end
    tick();
  endtask
  task automatic flush_pipe();
    repeat (3) begin nop(); tick(); end
  endtask
  task automatic test_load_use();
    flush_pipe();
    drive(0, 0, 0, 0, 8, 1, 1, 0);
    tick();
    drive(8, 0, 1, 0, 11, 1, 0, 0);
    total++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin bad++; $display("FAIL load_use_stall: got %b want 111", {hz.StallF, hz.StallD, hz.FlushE}); end
    tick();
    drive(8, 0, 1, 0, 11, 1, 0, 0);
    total++;
    if ({hz.StallF, hz.FlushE} !== 2'b00) begin bad++; $display("FAIL load_use_once: got %b want 00", {hz.StallF, hz.FlushE}); end
    tick();
    nop();
    total++;
    if (hz.ForwardAE !== 2'b01) begin bad++; $display("FAIL load_use_fwd: got %b want 01", hz.ForwardAE); end
    tick();
  endtask
  task automatic test_ex_mem_forward();
    flush_pipe();
    drive(0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    drive(9, 9, 1, 1, 12, 1, 0, 0);
    tick();
    nop();
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1010) begin bad++; $display("FAIL fwd_mem: got %b want 1010", {hz.ForwardAE, hz.ForwardBE}); end
    tick();
    flush_pipe();
    drive(0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    drive(1, 2, 1, 1, 0, 0, 0, 0);
    tick();
    drive(9, 9, 1, 1, 12, 1, 0, 0);
    tick();
    nop();
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0101) begin bad++; $display("FAIL fwd_wb: got %b want 0101", {hz.ForwardAE, hz.ForwardBE}); end
    tick();
  endtask
  task automatic test_double_match();
    flush_pipe();
    drive(0, 0, 0, 0, 10, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 10, 1, 0, 0);
    tick();
    drive(10, 3, 1, 1, 4, 1, 0, 0);
    tick();
    nop();
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1000) begin bad++; $display("FAIL double_match: got %b want 1000", {hz.ForwardAE, hz.ForwardBE}); end
    tick();
  endtask
  task automatic test_branch_vs_stall();
    flush_pipe();
    drive(0, 0, 0, 0, 12, 1, 1, 0);
    tick();
    drive(12, 12, 1, 1, 13, 1, 0, 1);
    total++;
    if (outs() !== 9'b001110000) begin bad++; $display("FAIL branch_prio: got %b want %b", outs(), 9'b001110000); end
    tick();
    drive(13, 12, 1, 1, 0, 0, 0, 0);
    total++;
    if (outs() !== 9'd0) begin bad++; $display("FAIL branch_after: got %b want %b", outs(), 9'd0); end
    tick();
  endtask
  task automatic test_r0();
    flush_pipe();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 1, 7, 1, 0, 0);
    total++;
    if ({hz.StallF, hz.FlushE} !== 2'b00) begin bad++; $display("FAIL r0_stall: got %b want 00", {hz.StallF, hz.FlushE}); end
    tick();
    nop();
    total++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin bad++; $display("FAIL r0_fwd: got %b want 0000", {hz.ForwardAE, hz.ForwardBE}); end
    tick();
  endtask
  task automatic test_random();
    bit [8:0] e;
    for (int i = 0; i < 300; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      e = m_outs();
      total++;
      if (outs() !== e) begin bad++; $display("FAIL random_outs[%0d]: got %b want %b", i, outs(), e); end
      if (i == 150) begin
        RST_N = 1'b0;
        #1;
        total++;
        if (outs() !== 9'd0) begin bad++; $display("FAIL mid_reset: got %b want %b", outs(), 9'd0); end
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
      end else tick();
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (hz.StallCnt !== CW'(exp_sc)) begin bad++; $display("FAIL random_stallcnt: got %0d want %0d", hz.StallCnt, exp_sc); end
    total++;
    if (hz.FlushCnt !== CW'(exp_fc)) begin bad++; $display("FAIL random_flushcnt: got %0d want %0d", hz.FlushCnt, exp_fc); end
`else
    total++;
    if ({hz.StallCnt, hz.FlushCnt} !== 32'd0) begin bad++; $display("FAIL random_cnt_off: got %h want 0", {hz.StallCnt, hz.FlushCnt}); end
`endif
  endtask
  task automatic test_stats();
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    model_reset();
    repeat (3) begin
      drive(0, 0, 0, 0, 5, 1, 1, 0);
      tick();
      drive(0, 5, 0, 1, 6, 1, 0, 0);
      tick();
      drive(0, 5, 0, 1, 6, 1, 0, 0);
      tick();
    end
    repeat (2) begin nop(1'b1); tick(); end
    nop();
`ifdef HAZARD_STATS_EN
    total++;
    if (hz.StallCnt !== CW'(3)) begin bad++; $display("FAIL stats_stall: got %0d want 3", hz.StallCnt); end
    total++;
    if (hz.FlushCnt !== CW'(2)) begin bad++; $display("FAIL stats_flush: got %0d want 2", hz.FlushCnt); end
`else
    total++;
    if ({hz.StallCnt, hz.FlushCnt} !== 32'd0) begin bad++; $display("FAIL stats_off: got %h want 0", {hz.StallCnt, hz.FlushCnt}); end
`endif
    total++;
    if (exp_sc != 3 || exp_fc != 2) begin bad++; $display("FAIL stats_model: got %0d/%0d want 3/2", exp_sc, exp_fc); end
    tick();
  endtask
  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_load_use();
    test_ex_mem_forward();
    test_double_match();
    test_branch_vs_stall();
    test_r0();
    test_random();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
